// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/sub FPU among NREQ requesters.
// Optional ISSUE watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_addsub_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    input  logic [NREQ-1:0]      req_sel_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 fpu_start_o,
    output logic [31:0]          fpu_n1_o,
    output logic [31:0]          fpu_n2_o,
    output logic                 fpu_sel_o,
    input  logic [31:0]          fpu_result_i,
    input  logic                 fpu_done_i,
    input  logic                 fpu_busy_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fpu_addsub_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e              state_q;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       owner_q;
    logic [NREQ-1:0]     req_ready_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic                fpu_start_q;
    logic [31:0]         fpu_n1_q;
    logic [31:0]         fpu_n2_q;
    logic                fpu_sel_q;

    logic                grant_found_s;
    logic [IW-1:0]       grant_idx_s;
    logic                grant_ok_s;
    logic [NREQ-1:0]     grant_oh_s;
    logic [NREQ-1:0]     owner_oh_s;

`ifdef FPU_ARB_TIMEOUT_EN
    logic [15:0]         tmo_q;
    logic [15:0]         tmo_d;
    logic                rsp_err_q;
    assign tmo_d     = tmo_q + 16'd1;
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Round-robin search: first pending requester after the last winner, with wrap.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (!grant_found_s && req_valid_i[idx]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IW'(idx);
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // A stale done or a busy FPU blocks new grants.
    assign grant_ok_s = grant_found_s & ~fpu_busy_i & ~fpu_done_i;
    assign grant_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    assign owner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_RST;
            owner_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'h0000_0000;
            fpu_start_q <= 1'b0;
            fpu_n1_q    <= 32'h0000_0000;
            fpu_n2_q    <= 32'h0000_0000;
            fpu_sel_q   <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_q       <= 16'd0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_ok_s) begin
                        req_ready_q <= grant_oh_s;
                        fpu_n1_q    <= req_a_i[32*grant_idx_s +: 32];
                        fpu_n2_q    <= req_b_i[32*grant_idx_s +: 32];
                        fpu_sel_q   <= req_sel_i[grant_idx_s];
                        fpu_start_q <= 1'b1;
                        last_q      <= grant_idx_s;
                        owner_q     <= grant_idx_s;
                        state_q     <= ST_ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
                        tmo_q       <= 16'd0;
`endif
                    end else begin
                        fpu_start_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (fpu_done_i) begin
                        rsp_data_q  <= fpu_result_i;
                        rsp_valid_q <= owner_oh_s;
                        fpu_start_q <= 1'b0;
                        state_q     <= ST_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_d >= 16'(TIMEOUT_CYCLES)) begin
                        // Hung FPU: release the requester with a qNaN and the error flag.
                        rsp_data_q  <= 32'h7FC0_0000;
                        rsp_valid_q <= owner_oh_s;
                        rsp_err_q   <= 1'b1;
                        fpu_start_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        tmo_q       <= tmo_d;
                        fpu_start_q <= 1'b1;
                    end
`else
                    end else begin
                        fpu_start_q <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= rsp_valid_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= '0;
                    fpu_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign fpu_start_o = fpu_start_q;
    assign fpu_n1_o    = fpu_n1_q;
    assign fpu_n2_o    = fpu_n2_q;
    assign fpu_sel_o   = fpu_sel_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a behavioural FPU stub (done 7 cycles after start).
module tb_fpu_addsub_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 32;

    typedef struct {
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_sel;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic                fpu_start;
    logic [31:0]         fpu_n1;
    logic [31:0]         fpu_n2;
    logic                fpu_sel;
    logic [31:0]         fpu_result;
    logic                fpu_done;
    logic                fpu_busy;

    logic [3:0]          st_cnt;
    logic [1:0]          st_drop;
    logic                stub_hang = 1'b0;
    logic                outstanding;
    int                  bad_cnt;
    int                  chk_cnt  = 0;
    int                  pass_cnt = 0;
    vec_t                vecs[5];

    always #5 clk = ~clk;

    fpu_addsub_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_sel_i    (req_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .fpu_start_o  (fpu_start),
        .fpu_n1_o     (fpu_n1),
        .fpu_n2_o     (fpu_n2),
        .fpu_sel_o    (fpu_sel),
        .fpu_result_i (fpu_result),
        .fpu_done_i   (fpu_done),
        .fpu_busy_i   (fpu_busy)
    );

    // Result lookup: unknown operand sets yield a poison word.
    function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b, input logic s);
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].a == a && vecs[i].b == b && vecs[i].sel == s) return vecs[i].exp;
        end
        return 32'hDEAD_BEEF;
    endfunction

    // FPU stub: done rises 7 cycles after start, falls 2 cycles after start falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_busy   <= 1'b0;
            fpu_done   <= 1'b0;
            fpu_result <= 32'h0;
            st_cnt     <= 4'd0;
            st_drop    <= 2'd0;
        end else if (stub_hang) begin
            fpu_busy   <= 1'b0;
            fpu_done   <= 1'b0;
        end else if (!fpu_busy) begin
            if (fpu_start) begin
                fpu_busy <= 1'b1;
                st_cnt   <= 4'd1;
                st_drop  <= 2'd0;
            end
        end else if (!fpu_done) begin
            st_cnt <= st_cnt + 4'd1;
            if (st_cnt == 4'd6) begin
                fpu_done   <= 1'b1;
                fpu_result <= lookup(fpu_n1, fpu_n2, fpu_sel);
            end
        end else if (!fpu_start) begin
            if (st_drop == 2'd1) begin
                fpu_done <= 1'b0;
                fpu_busy <= 1'b0;
            end else begin
                st_drop <= st_drop + 2'd1;
            end
        end
    end

    // Protocol monitor: no grant while a response is outstanding, all one-hot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
        end else begin
            if (|req_ready) begin
                if (outstanding || $countones(req_ready) != 1) bad_cnt <= bad_cnt + 1;
                outstanding <= 1'b1;
            end else if (|(rsp_valid & rsp_ready)) begin
                outstanding <= 1'b0;
            end
            if ($countones(rsp_valid) > 1) bad_cnt <= bad_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic set_req(input int g, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*g +: 32] = a;
        req_b[32*g +: 32] = b;
        req_sel[g]        = s;
    endtask

    // One operation: wait for grant to g, check handshake, latency and result, accept.
    task automatic run_op(input int g, input logic [31:0] exp_d, input logic exp_err,
                          input int exp_lat, input logic drop);
        int w;
        int lat;
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[g] = 1'b1;
        w = 0;
        while (req_ready === '0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            chk("grant_timeout", 32'(w), 32'd0);
            return;
        end
        chk("grant_onehot", 32'(req_ready), 32'(oh));
        chk("grant_start", 32'(fpu_start), 32'd1);
        chk("grant_n1", fpu_n1, req_a[32*g +: 32]);
        chk("grant_n2", fpu_n2, req_b[32*g +: 32]);
        chk("grant_sel", 32'(fpu_sel), 32'(req_sel[g]));
        if (drop) req_valid[g] = 1'b0;
        lat = 0;
        while (rsp_valid === '0 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("ready_pulse", 32'(req_ready), 32'd0);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_start_low", 32'(fpu_start), 32'd0);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_accept", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int w;
        int seen;
        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000};
        vecs[1] = '{1, 32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000};
        vecs[2] = '{0, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000};
        vecs[3] = '{1, 32'hBF80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000};
        vecs[4] = '{1, 32'h4120_0000, 32'hC0A0_0000, 1'b1, 32'h4170_0000};
        bad_cnt   = 0;
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_fpu_n1", fpu_n1, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].sel);
            req_valid[vecs[i].g] = 1'b1;
            run_op(vecs[i].g, vecs[i].exp, 1'b0, 8, 1'b1);
        end

        // Contention: both held, expect 0,1,0,1.
        set_req(0, vecs[0].a, vecs[0].b, vecs[0].sel);
        set_req(1, vecs[1].a, vecs[1].b, vecs[1].sel);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) run_op(i % 2, vecs[i % 2].exp, 1'b0, 8, 1'b0);
        req_valid = '0;

        // Backpressure, foreign rsp_ready ignored, request withdrawn before grant.
        req_valid = 2'b01;
        w = 0;
        while (req_ready === '0 && w < 100) begin @(negedge clk); w++; end
        req_valid = '0;
        while (rsp_valid === '0 && w < 200) begin @(negedge clk); w++; end
        chk("bp_reach_rsp", 32'(w < 200), 32'd1);
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 5) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, vecs[0].exp);
            chk("bp_start", 32'(fpu_start), 32'd0);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        chk("bp_accept", 32'(rsp_valid), 32'd0);
        seen = 0;
        repeat (15) begin @(negedge clk); if (req_ready !== '0) seen++; end
        chk("withdrawn_no_grant", 32'(seen), 32'd0);
        req_valid = 2'b10;
        run_op(1, vecs[1].exp, 1'b0, 8, 1'b1);

        // Reset three cycles into ISSUE.
        req_valid = 2'b01;
        w = 0;
        while (req_ready === '0 && w < 100) begin @(negedge clk); w++; end
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_data", rsp_data, 32'd0);
        chk("mrst_fpu_start", 32'(fpu_start), 32'd0);
        chk("mrst_fpu_n1", fpu_n1, 32'd0);
        chk("mrst_fpu_n2", fpu_n2, 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid !== '0) seen++; end
        chk("mrst_no_rsp", 32'(seen), 32'd0);
        req_valid = 2'b11;
        run_op(0, vecs[0].exp, 1'b0, 8, 1'b1);
        run_op(1, vecs[1].exp, 1'b0, 8, 1'b1);

`ifdef FPU_ARB_TIMEOUT_EN
        stub_hang = 1'b1;
        req_valid = 2'b01;
        run_op(0, 32'h7FC0_0000, 1'b1, TMO, 1'b1);
        stub_hang = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("single_outstanding", 32'(bad_cnt), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AddSubFPU_FSM instance between NREQ requesters, for example the issue lanes or the FMA/convert helpers.
- Accepts operand requests, drives the FPU start/done handshake, and returns each result to its owner with valid/ready backpressure.
- Sits between the FP issue logic and the add/sub unit. Only one operation is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 32, watchdog limit in ISSUE; used only with FPU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot, one-cycle grant acknowledge.
- req_a  in  32*NREQ  operand N1; requester i occupies bits [32i+31:32i].
- req_b  in  32*NREQ  operand N2, same packing.
- req_sel  in  NREQ  per-requester op: 0 = add, 1 = sub.
- rsp_valid  out  NREQ  one-hot; result pending for that requester.
- rsp_ready  in  NREQ  requester accepts the result.
- rsp_data  out  32  result word, shared by all requesters.
- rsp_err  out  1  watchdog error flag for the current response.
- fpu_start  out  1  to FPU start.
- fpu_n1  out  32  to FPU N1.
- fpu_n2  out  32  to FPU N2.
- fpu_sel  out  1  to FPU sel.
- fpu_result  in  32  from FPU result.
- fpu_done  in  1  from FPU done.
- fpu_busy  in  1  from FPU busy.

Behaviour:
- Reset, asynchronous on rst_n low, wins over everything:
  - state = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - fpu_start = 0, fpu_n1 = 0, fpu_n2 = 0, fpu_sel = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has top priority first.
- Reset mid-operation: the in-flight operation is dropped with no response. The FPU has its own reset.
- All outputs are registered. The state machine has three states: IDLE, ISSUE, RESP.
- IDLE:
  - A grant needs |req_valid, fpu_busy == 0 and fpu_done == 0.
  - The winner is the first set bit searching last+1, last+2, ... with wrap-around modulo NREQ.
  - On grant: req_ready[g] = 1 for exactly one cycle; fpu_n1, fpu_n2, fpu_sel are latched from slice g; fpu_start = 1; last = g; owner = g; go to ISSUE.
  - Operands stay stable in the FPU-facing registers until the next grant. Requester inputs may change after req_ready.
- ISSUE:
  - fpu_start is held at 1.
  - On fpu_done == 1: rsp_data = fpu_result, rsp_err = 0, rsp_valid[owner] = 1, fpu_start = 0, go to RESP.
- RESP:
  - rsp_valid[owner] and rsp_data are held until rsp_ready[owner] is 1. rsp_ready of other requesters is ignored.
  - On acceptance: rsp_valid = 0, go to IDLE. A new grant is possible in the following IDLE cycle, subject to fpu_busy/fpu_done both being 0.
  - The FPU drops done two cycles after start falls, so back-to-back issues are naturally gated.
- Latency: grant to rsp_valid = (FPU done latency, 7 cycles for AddSubFPU_FSM) + 1.
- Boundary conditions:
  - Simultaneous requests: only one is granted per operation. A losing requester keeps req_valid high and is granted next in rotation. No starvation: worst-case wait is NREQ-1 operations.
  - req_valid dropped before grant is legal, and no grant is issued for it.
  - A requester that is currently the owner may raise a new req_valid. It is served only after its response is accepted.
  - rsp_ready with no rsp_valid has no effect.
  - fpu_done high while in IDLE (stale) blocks granting until it falls.

Optional Feature:
- Macro: FPU_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without fpu_done: fpu_start = 0, rsp_data = 32'h7FC00000 (qNaN), rsp_err = 1, rsp_valid[owner] = 1, go to RESP.
  - The IDLE grant condition still applies, so a hung FPU blocks further grants but the requester is released.
- Without the macro: no counter, rsp_err is tied to 0, and ISSUE waits indefinitely.

Test Plan:
- Single add: req0 a=0x3F800000, b=0x40000000, sel=0 -> req_ready[0] one cycle; rsp_valid[0] with rsp_data=0x40400000 exactly 8 cycles after grant; rsp_err=0.
- Subtract via req1: a=0x40A00000, b=0x40400000, sel=1 -> rsp_valid[1], rsp_data=0x40000000; req_ready[0] and rsp_valid[0] never set.
- Contention: req_valid=2'b11 held with distinct operands -> grants 0,1,0,1 in order; each rsp_valid matches its own operands; never two grants while one is outstanding.
- Backpressure: rsp_ready[0]=0 for 10 cycles -> rsp_valid[0] and rsp_data stable; fpu_start stays 0; no new grant until acceptance.
- Reset mid-ISSUE: rst_n low for 1 cycle, 3 cycles after grant -> all outputs 0 immediately; no rsp_valid afterwards; next request granted to requester 0 first.
- Timeout (macro on, stub FPU never asserts done, TIMEOUT_CYCLES=32) -> 32 cycles after grant: rsp_valid[owner]=1, rsp_err=1, rsp_data=0x7FC00000, fpu_start=0.
